// File: rtl/icache_assoc_if.sv
// icache_assoc_if: bundles the two handshakes around the instruction cache.
//   Fetch side : addr, valid (request, held until ready), ready (1-cycle pulse),
//                data (valid with ready), flush (1-cycle fence.i pulse).
//   Refill side: rstart (1-cycle pulse per word), raddr (held rstart..rok),
//                rok (1-cycle pulse), rdata (valid with rok).
// Handshake rules: a requester raises valid with a stable addr and keeps both
// until it sees the one-cycle ready pulse; data is only meaningful in that
// cycle. Each rstart launches exactly one word read whose completion is the
// next rok pulse, and raddr does not change in between.
// Modports: slave = the cache, master = the IFU/memory environment.
interface icache_assoc_if;
  logic [31:0] addr;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        flush;
  logic        rstart;
  logic [31:0] raddr;
  logic        rok;
  logic [31:0] rdata;

  modport slave (
    input  addr, valid, flush, rok, rdata,
    output ready, data, rstart, raddr
  );

  modport master (
    output addr, valid, flush, rok, rdata,
    input  ready, data, rstart, raddr
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways, per-set LRU)
// with multi-word blocks refilled one word at a time, whole-cache flush and
// hit/miss counters.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : icache_assoc_if.slave (fetch side + refill side)
//   hit_cnt        : number of hit responses (wraps)
//   miss_cnt       : number of refills started (wraps)
//   state_dbg      : current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module icache_assoc #(
  parameter int WAY_Ls  = 1,
  parameter int SET_Ls  = 4,
  parameter int WORD_Ls = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  icache_assoc_if.slave        bus,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [1:0]           state_dbg
);
  localparam int OFF_W = WORD_Ls + 2;
  localparam int IDX_W = SET_Ls;
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int WORDS = 2 ** WORD_Ls;
  localparam int WAYS  = 2 ** WAY_Ls;
  localparam int SETS  = 2 ** SET_Ls;
  localparam int BLK_W = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nxt;

  // Line storage; contents need no reset because the valid bits gate them.
  logic [31:0]      data_mem [WAYS][SETS][WORDS];
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [SETS-1:0]  vld      [WAYS];
  // lru[s] names the way to replace next in set s.
  logic [SETS-1:0]  lru;

  logic               ready_q;
  logic [31:0]        data_q;
  logic [BLK_W-1:0]   blk;        // {tag, set} of the block being refilled
  logic [0:0]         vic;
  logic [WORD_Ls-1:0] req_w;
  logic [WORD_Ls-1:0] cnt;
  logic               flush_pend;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_set;
  logic [WORD_Ls-1:0] req_word;
  logic [IDX_W-1:0]   blk_set;
  logic [TAG_W-1:0]   blk_tag;
  logic [WAYS-1:0]    match;
  logic [0:0]         hit_way;
  logic [0:0]         victim;
  logic               lookup, flushing, is_hit, is_miss, last_word;
  logic [1:0]         unused_addr_bits;

  assign req_tag          = bus.addr[31:OFF_W+IDX_W];
  assign req_set          = bus.addr[OFF_W+IDX_W-1:OFF_W];
  assign req_word         = bus.addr[OFF_W-1:2];
  assign unused_addr_bits = bus.addr[1:0];
  assign blk_set          = blk[IDX_W-1:0];
  assign blk_tag          = blk[BLK_W-1:IDX_W];
  assign last_word        = (cnt == WORD_Ls'(WORDS - 1));

  // The cycle right after a ready pulse never starts a lookup, which also
  // keeps ready from being high two cycles in a row.
  assign lookup   = (state == IDLE) && bus.valid && !ready_q;
  // A flush seen in the same cycle as a lookup forces a miss.
  assign flushing = bus.flush || flush_pend;
  assign is_hit   = lookup && !flushing && (|match);
  assign is_miss  = lookup && !is_hit;

  always_comb begin
    match   = '0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = vld[w][req_set] && (tag_mem[w][req_set] == req_tag);
      if (match[w]) hit_way = 1'(w);
    end
  end

  // Victim: first invalid way, otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!vld[0][req_set])             victim = 1'b0;
      else if (!vld[WAYS-1][req_set])   victim = 1'b1;
      else                              victim = lru[req_set];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (is_miss) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.rok) state_nxt = last_word ? RESP : ISSUE;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rstart = (state == ISSUE);
  assign bus.raddr  = {blk, cnt, 2'b00};
  assign bus.ready  = ready_q;
  assign bus.data   = data_q;
  assign state_dbg  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      data_q     <= '0;
      blk        <= '0;
      vic        <= '0;
      req_w      <= '0;
      cnt        <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      flush_pend <= 1'b0;
      lru        <= '0;
      for (int w = 0; w < WAYS; w++) vld[w] <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (flushing) begin
            for (int w = 0; w < WAYS; w++) vld[w] <= '0;
            lru        <= '0;
            flush_pend <= 1'b0;
          end
          if (is_hit) begin
            ready_q <= 1'b1;
            data_q  <= data_mem[hit_way][req_set][req_word];
            if (WAYS > 1) lru[req_set] <= ~hit_way;
            hit_cnt <= hit_cnt + 32'd1;
          end
          if (is_miss) begin
            vld[victim][req_set] <= 1'b0;
            blk      <= bus.addr[31:OFF_W];
            vic      <= victim;
            req_w    <= req_word;
            cnt      <= '0;
            miss_cnt <= miss_cnt + 32'd1;
          end
        end
        ISSUE: begin
          if (bus.flush) flush_pend <= 1'b1;
        end
        WAIT: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.rok) begin
            if (last_word) begin
              vld[vic][blk_set] <= 1'b1;
              ready_q <= 1'b1;
              // The last word is still in flight to the array this cycle.
              data_q  <= (req_w == cnt) ? bus.rdata : data_mem[vic][blk_set][req_w];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (WAYS > 1) lru[blk_set] <= ~vic;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == WAIT && bus.rok) begin
      data_mem[vic][blk_set][cnt] <= bus.rdata;
      if (last_word) tag_mem[vic][blk_set] <= blk_tag;
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: self-checking bench for icache_assoc (2-way, 16 sets,
// 4-word blocks). A reference model keeps, per set, the resident block
// addresses in most-recently-used order and predicts hit/miss, latency,
// refill addresses, returned data and both counters.
module tb_icache_assoc;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  icache_assoc_if bus();
  logic [31:0] hit_cnt, miss_cnt;
  logic [1:0]  state_dbg;

  icache_assoc #(.WAY_Ls(1), .SET_Ls(4), .WORD_Ls(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + ((a - 32'h8000_0000) >> 2);
  endfunction

  // ---------------- memory responder ----------------
  int          mem_delay = 1;
  int          pend = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] raddr_log[$];

  initial begin
    bus.rok   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clock);
      bus.rok = 1'b0;
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.rok   = 1'b1;
            bus.rdata = mem_word(pend_addr);
          end
        end
        if (bus.rstart) begin
          raddr_log.push_back(bus.raddr);
          pend_addr = bus.raddr;
          pend      = mem_delay;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [27:0] way_q [16][$];
  logic [31:0] exp_hit = '0;
  logic [31:0] exp_miss = '0;

  function automatic bit model_access(input logic [31:0] a);
    logic [27:0] b;
    int s;
    b = a[31:4];
    s = int'(b[3:0]);
    for (int i = 0; i < way_q[s].size(); i++) begin
      if (way_q[s][i] == b) begin
        way_q[s].delete(i);
        way_q[s].push_front(b);
        return 1'b1;
      end
    end
    if (way_q[s].size() >= 2) void'(way_q[s].pop_back());
    way_q[s].push_front(b);
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 16; s++) way_q[s].delete();
  endfunction

  // fmode: 0 plain, 1 flush together with the request, 2 flush in WAIT of word 1
  task automatic fetch(input logic [31:0] a, input int fmode);
    bit          exp_h, got;
    int          lat, nstart, fl_state, exp_lat;
    logic [31:0] exp_a;
    @(negedge clock);
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clock);
    raddr_log.delete();
    if (fmode == 1) model_flush();
    exp_h = model_access(a);
    bus.addr  = a;
    bus.valid = 1'b1;
    if (fmode == 1) bus.flush = 1'b1;
    lat = 0; nstart = 0; got = 1'b0; fl_state = 0;
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      bus.flush = 1'b0;
      if (fl_state == 1) begin
        bus.flush = 1'b1;
        fl_state  = 2;
      end
      if (bus.rstart) begin
        nstart++;
        if (fmode == 2 && nstart == 2) fl_state = 1;
      end
      if (bus.ready) got = 1'b1;
    end
    bus.valid = 1'b0;
    chk("ready_seen", 32'(got), 32'd1);
    exp_lat = exp_h ? 1 : 1 + 4 * (1 + mem_delay);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("data", bus.data, mem_word(a));
    chk("rstart_count", 32'(nstart), exp_h ? 32'd0 : 32'd4);
    if (!exp_h) begin
      chk("raddr_count", 32'(raddr_log.size()), 32'd4);
      for (int i = 0; i < raddr_log.size() && i < 4; i++) begin
        exp_a = {a[31:4], 4'h0} + 32'(i * 4);
        chk("raddr", raddr_log[i], exp_a);
      end
    end
    if (exp_h) exp_hit++;
    else       exp_miss++;
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
    @(negedge clock);
    chk("ready_drop", 32'(bus.ready), 32'd0);
    if (fmode == 2) model_flush();
  endtask

  task automatic idle_flush();
    @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    model_flush();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    bit          seen;
    bus.addr  = '0;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_data", bus.data, 32'd0);
    chk("rst_rstart", 32'(bus.rstart), 32'd0);
    chk("rst_raddr", bus.raddr, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;

    // Cold miss, same-block hit.
    fetch(32'h8000_0004, 0);
    fetch(32'h8000_0008, 0);

    // Conflict in set 0 with LRU replacement.
    fetch(32'h8000_0000, 0);
    fetch(32'h8000_0100, 0);
    fetch(32'h8000_0000, 0);
    fetch(32'h8000_0200, 0);
    fetch(32'h8000_0000, 0);
    fetch(32'h8000_010C, 0);
    chk("conflict_miss_cnt", miss_cnt, 32'd4);

    // Flush in IDLE, then flush together with a request.
    idle_flush();
    fetch(32'h8000_0000, 0);
    fetch(32'h8000_0000, 1);

    // Flush during refill: response intact, refetch misses.
    fetch(32'h8000_0304, 2);
    fetch(32'h8000_0304, 0);

    // Slower memory.
    mem_delay = 3;
    fetch(32'h8000_0414, 0);
    fetch(32'h8000_041C, 0);

    // Randomized traffic over a small address pool.
    repeat (60) begin
      mem_delay = $urandom_range(1, 3);
      a = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8)
                        | (32'($urandom_range(0, 3)) << 4)
                        | (32'($urandom_range(0, 3)) << 2);
      r = $urandom_range(0, 9);
      if (r == 0) idle_flush();
      fetch(a, (r == 1) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a refill.
    mem_delay = 1;
    @(negedge clock);
    bus.addr  = 32'h8000_0804;
    bus.valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (bus.rstart) seen = 1'b1;
    end
    chk("rst_mid_rstart_seen", 32'(seen), 32'd1);
    @(negedge clock);
    reset_n   = 1'b0;
    bus.valid = 1'b0;
    #1;
    chk("rst_mid_rstart", 32'(bus.rstart), 32'd0);
    chk("rst_mid_ready", 32'(bus.ready), 32'd0);
    chk("rst_mid_hit_cnt", hit_cnt, 32'd0);
    chk("rst_mid_miss_cnt", miss_cnt, 32'd0);
    chk("rst_mid_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    model_flush();
    exp_hit  = '0;
    exp_miss = '0;
    fetch(32'h8000_0804, 0);
    fetch(32'h8000_0808, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
